// File: rtl/soc_fp_pkg.sv
// Shared binary32 field definitions and FSM state encoding for the SOC share path.
package soc_fp_pkg;

    localparam int XLEN     = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int N_CELLS  = 4;
    localparam int DIV_BITS = 25;

    localparam logic [XLEN-1:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DIV  = 3'd2,
        NORM = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic [XLEN-1:0] fp_pack(input logic sign,
                                                 input logic [EXP_W-1:0] exp,
                                                 input logic [MAN_W-1:0] mant);
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fp_mant_div_serial.sv
// Restoring mantissa divider: q = floor(dividend * 2^24 / divisor), one quotient bit per step, MSB first.
module fp_mant_div_serial
    import soc_fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [MAN_W:0]      dividend,
    input  logic [MAN_W:0]      divisor,
    output logic [DIV_BITS-1:0] q,
    output logic                q_ready,
    output logic                last_bit
);

    logic [MAN_W+1:0] rem;
    logic [MAN_W:0]   dsr;
    logic [4:0]       cnt;
    logic [MAN_W+2:0] diff;
    logic             fits;
    logic [MAN_W:0]   rem_kept;

    // Both operands are normalised, so the partial remainder stays below 2*divisor.
    always_comb begin
        diff     = {1'b0, rem} - {2'b00, dsr};
        fits     = ~diff[MAN_W+2];
        rem_kept = fits ? diff[MAN_W:0] : rem[MAN_W:0];
    end

    assign last_bit = step && !q_ready && (cnt == 5'(DIV_BITS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem     <= '0;
            dsr     <= '0;
            q       <= '0;
            cnt     <= '0;
            q_ready <= 1'b0;
        end else if (load) begin
            rem     <= {1'b0, dividend};
            dsr     <= divisor;
            q       <= '0;
            cnt     <= '0;
            q_ready <= 1'b0;
        end else if (step && !q_ready) begin
            rem <= {rem_kept, 1'b0};
            q   <= {q[DIV_BITS-2:0], fits};
            if (cnt == 5'(DIV_BITS - 1)) q_ready <= 1'b1;
            else                         cnt     <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/soc_share_normalizer.sv
// Per-cell share num_i/den in binary32 (truncated), computed serially through one mantissa divider.
module soc_share_normalizer
    import soc_fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] num0,
    input  logic [XLEN-1:0] num1,
    input  logic [XLEN-1:0] num2,
    input  logic [XLEN-1:0] num3,
    input  logic [XLEN-1:0] den,
    output logic            busy,
    output logic            done,
    output logic            shares_valid,
    output logic [XLEN-1:0] share0,
    output logic [XLEN-1:0] share1,
    output logic [XLEN-1:0] share2,
    output logic [XLEN-1:0] share3,
    output logic            dz_flag,
    output logic            ovf_flag,
    output logic            unf_flag
);

    state_t              state;
    logic [1:0]          idx;
    logic [XLEN-1:0]     num_q   [N_CELLS];
    logic [XLEN-1:0]     share_q [N_CELLS];
    logic [XLEN-1:0]     den_q;
    logic [XLEN-1:0]     cur_num;
    logic                sign_q;
    logic signed [9:0]   e_q;

    logic [DIV_BITS-1:0] q;
    logic                q_ready;
    logic                div_last;

    logic signed [9:0]   exp_n;
    logic [MAN_W-1:0]    mant_n;
    logic [XLEN-1:0]     result;
    logic                hit_dz;
    logic                hit_ovf;
    logic                hit_unf;

    assign cur_num = num_q[idx];
    assign busy    = (state == LOAD) || (state == DIV) || (state == NORM);
    assign done    = (state == DONE);
    assign share0  = share_q[0];
    assign share1  = share_q[1];
    assign share2  = share_q[2];
    assign share3  = share_q[3];

    fp_mant_div_serial u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == LOAD),
        .step     (state == DIV),
        .dividend ({1'b1, cur_num[MAN_W-1:0]}),
        .divisor  ({1'b1, den_q[MAN_W-1:0]}),
        .q        (q),
        .q_ready  (q_ready),
        .last_bit (div_last)
    );

    // NOTE: every variable gets a default first so this block cannot infer a latch.
    always_comb begin
        exp_n   = q[DIV_BITS-1] ? e_q + 10'sd127 : e_q + 10'sd126;
        mant_n  = q[DIV_BITS-1] ? q[MAN_W:1] : q[MAN_W-1:0];
        result  = fp_pack(sign_q, exp_n[EXP_W-1:0], mant_n);
        hit_dz  = 1'b0;
        hit_ovf = 1'b0;
        hit_unf = 1'b0;
        if (den_q[XLEN-2:MAN_W] == '0) begin
            result = {sign_q, POS_INF[XLEN-2:0]};
            hit_dz = 1'b1;
        end else if (cur_num[XLEN-2:MAN_W] == '0) begin
            result = {sign_q, 31'h0};
        end else if (exp_n >= 10'sd255) begin
            result  = {sign_q, POS_INF[XLEN-2:0]};
            hit_ovf = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            result  = {sign_q, 31'h0};
            hit_unf = 1'b1;
        end
    end

    // NOTE: operand and share arrays are reset too, since every output must read 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            den_q        <= '0;
            sign_q       <= 1'b0;
            e_q          <= '0;
            shares_valid <= 1'b0;
            dz_flag      <= 1'b0;
            ovf_flag     <= 1'b0;
            unf_flag     <= 1'b0;
            for (int i = 0; i < N_CELLS; i++) begin
                num_q[i]   <= '0;
                share_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    num_q[0]     <= num0;
                    num_q[1]     <= num1;
                    num_q[2]     <= num2;
                    num_q[3]     <= num3;
                    den_q        <= den;
                    idx          <= '0;
                    shares_valid <= 1'b0;
                    dz_flag      <= 1'b0;
                    ovf_flag     <= 1'b0;
                    unf_flag     <= 1'b0;
                    state        <= LOAD;
                end
                LOAD: begin
                    sign_q <= cur_num[XLEN-1] ^ den_q[XLEN-1];
                    e_q    <= $signed({2'b00, cur_num[XLEN-2:MAN_W]})
                            - $signed({2'b00, den_q[XLEN-2:MAN_W]});
                    state  <= DIV;
                end
                DIV: if (div_last) state <= NORM;
                NORM: begin
                    if (q_ready) share_q[idx] <= result;
                    dz_flag  <= dz_flag  | hit_dz;
                    ovf_flag <= ovf_flag | hit_ovf;
                    unf_flag <= unf_flag | hit_unf;
                    if (idx == 2'(N_CELLS - 1)) begin
                        shares_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= LOAD;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
